// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
//   Shared definitions for the 96x64 OLED pixel path:
//     - RGB565 colour constants used by the screen renderers
//     - panel dimensions OLED_W / OLED_H
//     - state encoding of the loading-bar sequencing FSM
//     - max_int helper for sizing counters at elaboration
// -----------------------------------------------------------------------------
package oled_pkg;

    localparam logic [15:0] BLACK      = 16'h0000;
    localparam logic [15:0] WHITE      = 16'hFFFF;
    localparam logic [15:0] LIGHTGREEN = 16'hAFE5;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } lb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/loading_bar_seq_if.sv
// -----------------------------------------------------------------------------
// loading_bar_seq_if
//   Bundles the loading bar's control handshake and pixel bus.
//   master : the game-start screen controller / pixel scanner
//              drives start, abort, done_ack, x, y
//              reads  busy, done, progress, pix_hit, oled_data
//   slave  : loading_bar_seq (the opposite directions)
//   PROG_W must equal $clog2(NUM_SEGS+1) of the attached bar.
// -----------------------------------------------------------------------------
interface loading_bar_seq_if #(
    parameter int PROG_W = 3
);
    logic              start;
    logic              abort;
    logic              done_ack;
    logic [6:0]        x;
    logic [5:0]        y;
    logic              busy;
    logic              done;
    logic [PROG_W-1:0] progress;
    logic              pix_hit;
    logic [15:0]       oled_data;

    modport master (
        output start, abort, done_ack, x, y,
        input  busy, done, progress, pix_hit, oled_data
    );

    modport slave (
        input  start, abort, done_ack, x, y,
        output busy, done, progress, pix_hit, oled_data
    );
endinterface

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
//   Modulo-(last+1) tick counter. The modulus is a run-time input so one
//   counter can time several phases of different length.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : synchronous clear to 0 (wins over enable)
//     enable     : count this cycle
//     last       : terminal count value (period - 1)
//     tc         : high while enabled and sitting on the terminal count;
//                  the counter wraps to 0 on that edge
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);
    logic [WIDTH-1:0] count_reg;

    assign tc = enable && (count_reg == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/loading_bar_seq.sv
// -----------------------------------------------------------------------------
// loading_bar_seq
//   Self-timed loading-screen progress bar for the 96x64 OLED pixel path.
//   Sequencer: IDLE -start-> FILL (one segment per TICKS_PER_STEP cycles)
//              -> HOLD (HOLD_TICKS cycles) -> DONE (until done_ack) -> IDLE.
//   abort returns to IDLE from any state and beats start/done_ack.
//   Renders a 3 px chamfered frame around NUM_SEGS segments; segment k is
//   lit while k < progress. Pixel output is registered (1-cycle latency).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : loading_bar_seq_if.slave (start, abort, done_ack, x, y,
//                  busy, done, progress, pix_hit, oled_data)
//   Build option:
//     LOADING_BAR_BLINK_EN - frame blinks black/white every TICKS_PER_STEP
//                            cycles while busy; otherwise it is always black.
// -----------------------------------------------------------------------------
module loading_bar_seq
    import oled_pkg::*;
#(
    parameter int          NUM_SEGS       = 4,
    parameter int          SEG_W          = 17,
    parameter int          TICKS_PER_STEP = 6_250_000,
    parameter int          HOLD_TICKS     = 6_250_000,
    parameter int          BAR_X0         = 10,
    parameter int          BAR_Y0         = 26,
    parameter int          BAR_Y1         = 49,
    parameter logic [15:0] FILL_COLOUR    = LIGHTGREEN
) (
    input  logic             clk,
    input  logic             rst_n,
    loading_bar_seq_if.slave bus
);
    localparam int BAR_X1 = BAR_X0 + 7 + NUM_SEGS * (SEG_W + 1);
    localparam int PW     = $clog2(NUM_SEGS + 1);
    localparam int TW     = $clog2(max_int(TICKS_PER_STEP, HOLD_TICKS) + 1);

    localparam logic [TW-1:0] STEP_LAST = TW'(TICKS_PER_STEP - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
    localparam logic [PW-1:0] PROG_LAST = PW'(NUM_SEGS - 1);

    // ---------------------------------------------------------------- checks
    generate
        if (BAR_X1 > OLED_W - 1 || BAR_Y1 > OLED_H - 1) begin : g_bad_geometry
            $error("loading_bar_seq: bar does not fit on the 96x64 panel");
        end
        if (NUM_SEGS < 1 || NUM_SEGS > 8) begin : g_bad_num_segs
            $error("loading_bar_seq: NUM_SEGS must be 1..8");
        end
        if (TICKS_PER_STEP < 1 || HOLD_TICKS < 1) begin : g_bad_ticks
            $error("loading_bar_seq: TICKS_PER_STEP and HOLD_TICKS must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------ sequencer
    lb_state_t     state_reg;
    logic [PW-1:0] progress_reg;
    logic          busy_reg;
    logic          done_reg;

    logic          tick_clear;
    logic          tick_en;
    logic          tick_tc;
    logic [TW-1:0] tick_last;

    // The timer is held at 0 in IDLE, so FILL always starts from tick 0;
    // FILL->HOLD happens on a terminal count, which wraps it to 0 as well.
    assign tick_clear = bus.abort || (state_reg == ST_IDLE);
    assign tick_en    = (state_reg == ST_FILL) || (state_reg == ST_HOLD);
    assign tick_last  = (state_reg == ST_HOLD) ? HOLD_LAST : STEP_LAST;

    step_timer #(
        .WIDTH (TW)
    ) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tick_clear),
        .enable (tick_en),
        .last   (tick_last),
        .tc     (tick_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            progress_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (bus.abort) begin
            state_reg    <= ST_IDLE;
            progress_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg    <= ST_FILL;
                        progress_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (tick_tc) begin
                        progress_reg <= progress_reg + 1'b1;
                        if (progress_reg == PROG_LAST) begin
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_tc) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ack) begin
                        state_reg    <= ST_IDLE;
                        progress_reg <= '0;
                        done_reg     <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    progress_reg <= '0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.progress = progress_reg;

    // ------------------------------------------------------- geometry decode
    // Full-width integer compares so out-of-panel coordinates never alias.
    int px;
    int py;
    int prog_i;

    assign px     = int'(bus.x);
    assign py     = int'(bus.y);
    assign prog_i = int'(progress_reg);

    logic                in_screen;
    logic                on_frame;
    logic                on_lit_seg;
    logic                frame_visible;
    logic [NUM_SEGS-1:0] seg_lit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEGS; gi++) begin : g_seg
            localparam int SX0 = BAR_X0 + 4 + gi * (SEG_W + 1);
            localparam int SX1 = SX0 + SEG_W - 1;
            assign seg_lit[gi] = (px >= SX0) && (px <= SX1) &&
                                 (py >= BAR_Y0 + 4) && (py <= BAR_Y1 - 4) &&
                                 (prog_i > gi);
        end
    endgenerate

    // Vertical and horizontal frame strips do not meet at the corners, which
    // gives the frame its chamfered look.
    always_comb begin
        in_screen = (px < OLED_W) && (py < OLED_H);
        on_frame  = (((px >= BAR_X0) && (px <= BAR_X0 + 2)) ||
                     ((px >= BAR_X1 - 2) && (px <= BAR_X1))) &&
                    (py >= BAR_Y0 + 3) && (py <= BAR_Y1 - 3);
        on_frame  = on_frame ||
                    ((((py >= BAR_Y0) && (py <= BAR_Y0 + 2)) ||
                      ((py >= BAR_Y1 - 2) && (py <= BAR_Y1))) &&
                     (px >= BAR_X0 + 3) && (px <= BAR_X1 - 3));
        on_lit_seg = |seg_lit;
    end

`ifdef LOADING_BAR_BLINK_EN
    // Blink phase runs only while busy; it is parked at black (0) whenever
    // the bar is not busy, so every FILL entry starts on a black frame.
    logic          blink_white_reg;
    logic [TW-1:0] blink_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_white_reg <= 1'b0;
            blink_cnt_reg   <= '0;
        end else if (!busy_reg) begin
            blink_white_reg <= 1'b0;
            blink_cnt_reg   <= '0;
        end else if (blink_cnt_reg == STEP_LAST) begin
            blink_white_reg <= ~blink_white_reg;
            blink_cnt_reg   <= '0;
        end else begin
            blink_cnt_reg   <= blink_cnt_reg + 1'b1;
        end
    end

    assign frame_visible = on_frame && !blink_white_reg;
`else
    assign frame_visible = on_frame;
`endif

    // ---------------------------------------------------------- pixel output
    logic        pix_hit_reg;
    logic [15:0] oled_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_hit_reg   <= 1'b0;
            oled_data_reg <= WHITE;
        end else if (in_screen && frame_visible) begin
            pix_hit_reg   <= 1'b1;
            oled_data_reg <= BLACK;
        end else if (in_screen && on_lit_seg) begin
            pix_hit_reg   <= 1'b1;
            oled_data_reg <= FILL_COLOUR;
        end else begin
            pix_hit_reg   <= 1'b0;
            oled_data_reg <= WHITE;
        end
    end

    assign bus.pix_hit   = pix_hit_reg;
    assign bus.oled_data = oled_data_reg;

endmodule

// File: tb/tb_loading_bar_seq.sv
// -----------------------------------------------------------------------------
// tb_loading_bar_seq
//   Scoreboard bench for loading_bar_seq with TICKS_PER_STEP=4, HOLD_TICKS=3,
//   NUM_SEGS=4. Expectations are queued with the clock edge at which they
//   must hold and are compared 1 time unit after that edge.
//   Build option LOADING_BAR_BLINK_EN selects the blinking-frame expectations.
// -----------------------------------------------------------------------------
module tb_loading_bar_seq;

    localparam int TPS  = 4;
    localparam int HOLD = 3;
    localparam int NSEG = 4;

    localparam int K_PROG = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;
    localparam int K_PIX  = 3;
    localparam int K_HIT  = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] val;
        string       tag;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   edge_num;
    int   vec_count;
    int   miscompare_count;

    sb_entry_t sb_q[$];

    loading_bar_seq_if #(.PROG_W(3)) bus ();

    loading_bar_seq #(
        .NUM_SEGS       (NSEG),
        .SEG_W          (17),
        .TICKS_PER_STEP (TPS),
        .HOLD_TICKS     (HOLD),
        .BAR_X0         (10),
        .BAR_Y0         (26),
        .BAR_Y1         (49),
        .FILL_COLOUR    (16'hAFE5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edge_num);
        end else begin
            $display("ok   %s: %h (edge %0d)", tag, obs, edge_num);
        end
    endtask

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_PROG:  return {13'd0, bus.progress};
            K_BUSY:  return {15'd0, bus.busy};
            K_DONE:  return {15'd0, bus.done};
            K_PIX:   return bus.oled_data;
            default: return {15'd0, bus.pix_hit};
        endcase
    endfunction

    task automatic expect_at(input int due, input int kind,
                             input logic [15:0] val, input string tag);
        sb_entry_t e;
        e.due  = due;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain_sb();
        sb_entry_t keep[$];
        keep = {};
        foreach (sb_q[i]) begin
            if (sb_q[i].due <= edge_num)
                check_value(sb_q[i].tag, observe(sb_q[i].kind), sb_q[i].val);
            else
                keep.push_back(sb_q[i]);
        end
        sb_q = keep;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_num++;
        #1;
        drain_sb();
    endtask

    // Frame colour expected at edge S+e for a pixel on the frame, S = start edge.
    // The frame is busy for edges S..S+(NSEG*TPS+HOLD-1); the phase seen at
    // edge S+e is the one established at edge S+e-1.
    function automatic logic [15:0] frame_exp(input int e);
`ifdef LOADING_BAR_BLINK_EN
        int p;
        p = e - 1;
        if (p >= 0 && p < NSEG * TPS + HOLD && ((p / TPS) % 2) == 1)
            return 16'hFFFF;
        return 16'h0000;
`else
        return (e >= 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    initial begin
        int s;
        int a;
        edge_num         = 0;
        vec_count        = 0;
        miscompare_count = 0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.done_ack     = 1'b0;
        bus.x            = 7'd0;
        bus.y            = 6'd0;
        rst_n            = 1'b1;

        // Power-on reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        expect_at(edge_num, K_PROG, 16'd0, "por_progress");
        expect_at(edge_num, K_BUSY, 16'd0, "por_busy");
        expect_at(edge_num, K_PIX, 16'hFFFF, "por_oled");
        drain_sb();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of FILL must act without a clock edge.
        bus.start = 1'b1;
        tick();
        s = edge_num;
        bus.start = 1'b0;
        repeat (8) tick();
        bus.x = 7'd14;
        bus.y = 6'd30;
        expect_at(s + 9, K_PIX, 16'hAFE5, "pre_rst_lit_seg");
        expect_at(s + 9, K_PROG, 16'd2, "pre_rst_progress");
        tick();
        #2 rst_n = 1'b0;
        #1;
        expect_at(edge_num, K_PROG, 16'd0, "async_rst_progress");
        expect_at(edge_num, K_BUSY, 16'd0, "async_rst_busy");
        expect_at(edge_num, K_DONE, 16'd0, "async_rst_done");
        expect_at(edge_num, K_HIT, 16'd0, "async_rst_pix_hit");
        expect_at(edge_num, K_PIX, 16'hFFFF, "async_rst_oled");
        drain_sb();
        tick();
        rst_n = 1'b1;
        bus.x = 7'd0;
        bus.y = 6'd0;
        tick();

        // Full sequence with pixel probes, ignored start/done_ack, done handshake.
        bus.start = 1'b1;
        tick();
        s = edge_num;
        bus.start = 1'b0;
        expect_at(s + 1,  K_BUSY, 16'd1, "busy_first");
        expect_at(s + 3,  K_PROG, 16'd0, "prog_before_step");
        expect_at(s + 4,  K_PROG, 16'd1, "prog_first_step");
        expect_at(s + 6,  K_PROG, 16'd1, "done_ack_ignored_prog");
        expect_at(s + 6,  K_DONE, 16'd0, "done_ack_ignored_done");
        expect_at(s + 8,  K_PROG, 16'd2, "prog_two");
        expect_at(s + 9,  K_PIX,  16'hAFE5, "pix_lit_seg0");
        expect_at(s + 9,  K_HIT,  16'd1, "hit_lit_seg0");
        expect_at(s + 10, K_PIX,  16'hFFFF, "pix_unlit_seg2");
        expect_at(s + 10, K_HIT,  16'd0, "hit_unlit_seg2");
        expect_at(s + 11, K_PIX,  16'h0000, "pix_frame");
        expect_at(s + 11, K_HIT,  16'd1, "hit_frame");
        expect_at(s + 12, K_PIX,  16'hFFFF, "pix_gap");
        expect_at(s + 13, K_PIX,  16'hFFFF, "pix_offscreen");
        expect_at(s + 13, K_HIT,  16'd0, "hit_offscreen");
        expect_at(s + 14, K_PROG, 16'd3, "start_ignored_prog");
        expect_at(s + 14, K_BUSY, 16'd1, "start_ignored_busy");
        expect_at(s + 15, K_PROG, 16'd3, "prog_three");
        expect_at(s + 16, K_PROG, 16'd4, "prog_full");
        expect_at(s + 18, K_BUSY, 16'd1, "busy_last");
        expect_at(s + 18, K_DONE, 16'd0, "done_not_yet");
        expect_at(s + 19, K_BUSY, 16'd0, "busy_drop");
        expect_at(s + 19, K_DONE, 16'd1, "done_rise");
        expect_at(s + 25, K_DONE, 16'd1, "done_held");
        expect_at(s + 25, K_PROG, 16'd4, "prog_held_in_done");
        expect_at(s + 26, K_DONE, 16'd0, "done_acked");
        expect_at(s + 26, K_PROG, 16'd0, "prog_cleared_on_ack");
        for (int e = 14; e <= 30; e++) begin
            expect_at(s + e, K_PIX, frame_exp(e), $sformatf("frame_pix_e%0d", e));
            expect_at(s + e, K_HIT, (frame_exp(e) == 16'h0000) ? 16'd1 : 16'd0,
                      $sformatf("frame_hit_e%0d", e));
        end
        for (int j = 1; j <= 30; j++) begin
            bus.done_ack = (j == 6) || (j == 26);
            bus.start    = (j == 14);
            case (j)
                9:  begin bus.x = 7'd14;  bus.y = 6'd30; end
                10: begin bus.x = 7'd51;  bus.y = 6'd30; end
                11: begin bus.x = 7'd10;  bus.y = 6'd35; end
                12: begin bus.x = 7'd31;  bus.y = 6'd35; end
                13: begin bus.x = 7'd127; bus.y = 6'd63; end
                default: begin
                    if (j >= 14) begin
                        bus.x = 7'd10;
                        bus.y = 6'd35;
                    end
                end
            endcase
            tick();
        end
        bus.done_ack = 1'b0;
        bus.start    = 1'b0;

        // abort beats start; held start restarts FILL from tick 0.
        bus.start = 1'b1;
        tick();
        s = edge_num;
        bus.start = 1'b0;
        repeat (5) tick();
        a = s + 6;
        expect_at(a,     K_PROG, 16'd0, "abort_start_prog");
        expect_at(a,     K_BUSY, 16'd0, "abort_start_busy");
        expect_at(a + 1, K_BUSY, 16'd1, "restart_busy");
        expect_at(a + 2, K_PROG, 16'd0, "restart_prog_a2");
        expect_at(a + 4, K_PROG, 16'd0, "restart_prog_a4");
        expect_at(a + 5, K_PROG, 16'd1, "restart_first_step");
        expect_at(a + 7, K_PROG, 16'd0, "abort_fill_prog");
        expect_at(a + 7, K_BUSY, 16'd0, "abort_fill_busy");
        expect_at(a + 9, K_BUSY, 16'd0, "idle_after_abort");
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (3) tick();

        if (sb_q.size() != 0)
            check_value("scoreboard_leftover", 16'(sb_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
